// File: rtl/pipe_mem.sv
// pipe_mem: fixed-latency word memory with valid/ready handshakes and a credit-limited response FIFO.
// Define PIPE_MEM_OOR_EN to add resp_err and drop/flag out-of-range accesses instead of wrapping.
module pipe_mem #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int RESP_Q      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data
`ifdef PIPE_MEM_OOR_EN
    ,
    output logic              resp_err
`endif
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = (RESP_Q > 1) ? $clog2(RESP_Q) : 1;
    localparam int CNT_W = $clog2(RESP_Q + 1);
    localparam int OUT_W = $clog2(RESP_Q + LATENCY + 1);
`ifdef PIPE_MEM_OOR_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif

    logic [IDX_W-1:0] idx;
    logic             oor;
    logic             acc;
    logic             rd_acc;
    logic             wr_acc;
    logic             unused_addr;

    assign idx         = req_addr[IDX_W+1:2];
    assign unused_addr = ^req_addr;
`ifdef PIPE_MEM_OOR_EN
    assign oor = (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));
`else
    assign oor = 1'b0;
`endif

    assign acc    = req_valid && req_ready;
    assign rd_acc = acc && !req_op;
    assign wr_acc = acc && req_op && !oor;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [EW-1:0]     rd_entry;
    logic [EW-1:0]     dl_data [LATENCY];
    logic [LATENCY-1:0] dl_valid;

    // Pipeline entries carry the error flag as an extra MSB when range checking is built in.
`ifdef PIPE_MEM_OOR_EN
    assign rd_entry = oor ? {1'b1, {DATA_W{1'b0}}} : {1'b0, mem[idx]};
`else
    assign rd_entry = mem[idx];
`endif

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[idx] <= req_wdata;
        end
        dl_data[0] <= rd_entry;
        for (int i = 1; i < LATENCY; i++) begin
            dl_data[i] <= dl_data[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= rd_acc;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    logic [EW-1:0]      fifo_mem [RESP_Q];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [OUT_W-1:0]   outstanding;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_Q - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push       = dl_valid[LATENCY-1];
    assign pop        = resp_valid && resp_ready;
    assign resp_valid = (count != '0);
    assign resp_data  = fifo_mem[rd_ptr][DATA_W-1:0];
`ifdef PIPE_MEM_OOR_EN
    assign resp_err   = fifo_mem[rd_ptr][DATA_W];
`endif

    // Credits cover reads still in the delay line as well as queued ones; a same-cycle pop is not counted.
    always_comb begin
        outstanding = OUT_W'(count);
        for (int i = 0; i < LATENCY; i++) begin
            outstanding = outstanding + OUT_W'(dl_valid[i]);
        end
    end

    assign req_ready = (outstanding < OUT_W'(RESP_Q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RESP_Q; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= dl_data[LATENCY-1];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (count == CNT_W'(RESP_Q))));

endmodule

// File: tb/tb_pipe_mem.sv
// tb_pipe_mem: randomized and directed stimulus for pipe_mem, checked against a queue-based reference model.
module tb_pipe_mem;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int LAT    = 2;
    localparam int RQ     = 4;
    localparam int IDX_W  = 10;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              req_valid  = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr   = '0;
    logic              req_op     = 1'b0;
    logic [DATA_W-1:0] req_wdata  = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_data;
`ifdef PIPE_MEM_OOR_EN
    logic              resp_err;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        int                avail;
    } resp_t;

    resp_t             exp_q[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    pipe_mem #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .RESP_Q(RQ)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_op     (req_op),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
`ifdef PIPE_MEM_OOR_EN
        ,
        .resp_err   (resp_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    endtask

    // One clock: check outputs against the model, drive new inputs, advance the model to the next edge.
    task automatic step(input logic v, input logic op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic rr);
        logic  exp_ready;
        logic  exp_valid;
        logic  oor;
        int    widx;
        resp_t r;
        @(negedge clk);
        exp_ready = (exp_q.size() < RQ);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        chk("req_ready", req_ready, exp_ready);
        chk("resp_valid", resp_valid, exp_valid);
        if (exp_valid) begin
            chk("resp_data", resp_data, exp_q[0].data);
`ifdef PIPE_MEM_OOR_EN
            chk("resp_err", resp_err, exp_q[0].err);
`endif
        end
        req_valid  = v;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = rr;
        if (exp_valid && rr) void'(exp_q.pop_front());
        widx = int'((addr >> 2) % DEPTH);
        oor  = 1'b0;
`ifdef PIPE_MEM_OOR_EN
        oor  = ((addr >> 2) >= DEPTH);
`endif
        if (v && exp_ready) begin
            if (op) begin
                if (!oor) ref_mem[widx] = wd;
            end else begin
                r.data  = oor ? '0 : ref_mem[widx];
                r.err   = oor;
                r.avail = cyc + 1 + LAT;
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, rr);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        reset_n    = 1'b0;
        #2;
        chk("rst resp_valid", resp_valid, 1'b0);
        chk("rst resp_data", resp_data, 32'h0);
        chk("rst req_ready", req_ready, 1'b1);
        #2;
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] hi;
        logic [31:0] wi;
        wi = 32'($urandom_range(0, 63));
        hi = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 15)) : 32'h0;
        return (hi << (IDX_W + 2)) | (wi << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset resp_valid", resp_valid, 1'b0);
        chk("reset resp_data", resp_data, 32'h0);
        chk("reset req_ready", req_ready, 1'b1);

        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b1);

        // basic read
        step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        idle(4, 1'b1);

        // streaming
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(i * 4), 32'(i + 1), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1);
        idle(6, 1'b1);

        // back-pressure
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
        idle(3, 1'b0);
        idle(8, 1'b1);

        // write-then-read hazard
        step(1'b1, 1'b1, 32'h20, 32'h55, 1'b1);
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h20, 32'h66, 1'b1);
        idle(4, 1'b1);
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        idle(4, 1'b1);

        // reset with reads in flight
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
        reset_pulse();
        idle(4, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        idle(6, 1'b1);

        // address beyond the array: error in range-checked builds, alias of word 0 otherwise
        step(1'b1, 1'b0, 32'h1000, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h1000, 32'hBAD0BAD0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(6, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) reset_pulse();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rand_addr(), $urandom,
                 $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
